// File: rtl/instruction_loader_pkg.sv
// Shared loader constants: the end-of-program marker used by fetch/decode and the loader state encoding.
package instruction_loader_pkg;

    localparam int unsigned    NB_DEFAULT      = 32;
    localparam int unsigned    NB_BYTE_DEFAULT = 8;
    localparam int unsigned    TAM_DEFAULT     = 256;
    localparam logic [31:0]    HALT_INSTR      = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } loader_state_e;

endpackage

// File: rtl/instruction_loader_byte_assembler.sv
// Shifts received bytes MSB-first into a word; flags the byte that completes a word.
module byte_assembler
    import instruction_loader_pkg::*;
#(
    parameter int unsigned NB      = NB_DEFAULT,
    parameter int unsigned NB_BYTE = NB_BYTE_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_shift,
    input  logic [NB_BYTE-1:0] i_byte,
    output logic [NB-1:0]      o_word,
    output logic               o_word_ready
);

    logic [NB-1:0] word_q, word_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;

    always_comb begin
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        if (i_clear) begin
            word_d     = '0;
            byte_cnt_d = '0;
        end else if (i_shift) begin
            word_d     = {word_q[NB-NB_BYTE-1:0], i_byte};
            byte_cnt_d = byte_cnt_q + 2'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            word_q     <= '0;
            byte_cnt_q <= '0;
        end else begin
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    // o_word already includes the byte being shifted so the completed word can be captured on this edge.
    assign o_word       = word_d;
    assign o_word_ready = i_shift && !i_clear && (byte_cnt_q == 2'd3);

endmodule

// File: rtl/instruction_loader.sv
// Loads a program into instruction memory from a UART byte stream, one 32-bit word per write.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no session, bytes ignored
// ST_RECV  | assembling bytes into the next word
// ST_WRITE | single-cycle memory write of the assembled word
// ST_DONE  | HALT word stored, session finished
// ST_ERROR | memory filled without a HALT word
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int unsigned    NB         = NB_DEFAULT,
    parameter int unsigned    NB_BYTE    = NB_BYTE_DEFAULT,
    parameter int unsigned    TAM        = TAM_DEFAULT,
    parameter logic [NB-1:0]  HALT_WORD  = HALT_INSTR,
    localparam int unsigned   WCW        = $clog2(TAM) + 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_rx_valid,
    input  logic [NB_BYTE-1:0] i_rx_data,
    output logic               o_wr_en,
    output logic [NB-1:0]      o_wr_addr,
    output logic [NB-1:0]      o_wr_data,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_overflow,
    output logic [WCW-1:0]     o_word_count
);

    loader_state_e state_q, state_d;
    logic [NB-1:0]  addr_q, addr_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic           wr_en_q, wr_en_d;
    logic [NB-1:0]  wr_addr_q, wr_addr_d;
    logic [NB-1:0]  wr_data_q, wr_data_d;

    logic           asm_shift;
    logic           asm_ready;
    logic [NB-1:0]  asm_word;

    // A byte arriving during WRITE starts the next word, so back-to-back strobes are never lost.
    assign asm_shift = i_rx_valid && !i_start &&
                       ((state_q == ST_RECV) || (state_q == ST_WRITE));

    byte_assembler #(
        .NB      (NB),
        .NB_BYTE (NB_BYTE)
    ) u_byte_assembler (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (i_start),
        .i_shift      (asm_shift),
        .i_byte       (i_rx_data),
        .o_word       (asm_word),
        .o_word_ready (asm_ready)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        word_cnt_d = word_cnt_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        if (i_start) begin
            state_d    = ST_RECV;
            addr_d     = '0;
            word_cnt_d = '0;
        end else begin
            case (state_q)
                ST_RECV: begin
                    if (asm_ready) begin
                        state_d    = ST_WRITE;
                        wr_en_d    = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = asm_word;
                        addr_d     = addr_q + NB'(4);
                        word_cnt_d = word_cnt_q + WCW'(1);
                    end
                end
                ST_WRITE: begin
                    // Counter was bumped on entry, so reaching TAM here means the memory is full.
                    if (wr_data_q == HALT_WORD)
                        state_d = ST_DONE;
                    else if (word_cnt_q == WCW'(TAM))
                        state_d = ST_ERROR;
                    else
                        state_d = ST_RECV;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            word_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            word_cnt_q <= word_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign o_wr_en      = wr_en_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;
    assign o_busy       = (state_q == ST_RECV) || (state_q == ST_WRITE);
    assign o_done       = (state_q == ST_DONE);
    assign o_overflow   = (state_q == ST_ERROR);
    assign o_word_count = word_cnt_q;

endmodule
